// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_arb_pkg
// Purpose : Shared types and helpers for the two-requester SRAM port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

  // Arbiter ownership states: free, or locked to one requester mid-burst
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Requester index (0 = AXI datapath, 1 = backdoor load/debug engine)
  typedef logic req_idx_t;

  // Byte-lane count of an SRAM row
  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module  : sram_arb_rr2
// Purpose : Two-way round-robin picker. Produces a one-hot winner from the
//           request pair; the pointer breaks ties only.
// Revision: 1.0 - initial release
// ============================================================================
module sram_arb_rr2
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   ptr,
  output logic [1:0] win
);

  // Single requester always wins; on contention the pointer side wins
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = ptr ? 2'b10 : 2'b01;
      default: win = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sram_port_arb.sv
`default_nettype none
// ============================================================================
// Module  : sram_port_arb
// Purpose : Shares one single-port 128-bit SRAM between two requesters with
//           per-beat grants, burst locking until a last beat, round-robin
//           between bursts and a watchdog that frees a stalled lock owner.
//           SRAM controls follow the active-low spsram macro convention.
// Revision: 1.0 - initial release
// ============================================================================
module sram_port_arb
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 128,
  parameter int LOCK_TO = 64
) (
  input  logic                      clk,
  input  logic                      rst_b,
  // requester 0
  input  logic                      m0_req,
  input  logic                      m0_last,
  input  logic [ADDR_W-1:0]         m0_addr,
  input  logic                      m0_wen,
  input  logic [strb_w(DATA_W)-1:0] m0_wstrb,
  input  logic [DATA_W-1:0]         m0_wdata,
  output logic                      m0_gnt,
  output logic                      m0_rvld,
  output logic [DATA_W-1:0]         m0_rdata,
  // requester 1
  input  logic                      m1_req,
  input  logic                      m1_last,
  input  logic [ADDR_W-1:0]         m1_addr,
  input  logic                      m1_wen,
  input  logic [strb_w(DATA_W)-1:0] m1_wstrb,
  input  logic [DATA_W-1:0]         m1_wdata,
  output logic                      m1_gnt,
  output logic                      m1_rvld,
  output logic [DATA_W-1:0]         m1_rdata,
  // SRAM macro
  output logic                      ram_cen,
  output logic                      ram_gwen,
  output logic [strb_w(DATA_W)-1:0] ram_wen,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_din,
  input  logic [DATA_W-1:0]         ram_dout,
  // status
  output logic                      lock_err
);

  localparam int STRB_W = strb_w(DATA_W);
  localparam int CNT_W  = $clog2(LOCK_TO);
  // Last idle count before release: the release edge is the LOCK_TO-th idle cycle
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(LOCK_TO - 1);

  arb_state_t        state;
  req_idx_t          rr_ptr;
  logic [CNT_W-1:0]  wd_cnt;
  logic [1:0]        pick;
  logic              any_gnt;
  logic              win_last;
  logic              win_wen;
  logic [STRB_W-1:0] win_strb;

  sram_arb_rr2 u_rr2 (
    .req (ramp_req()),
    .ptr (rr_ptr),
    .win (pick)
  );

  function automatic logic [1:0] ramp_req();
    return {m1_req, m0_req};
  endfunction

  // Grant: free arbitration in IDLE, otherwise only the lock owner may proceed
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    case (state)
      IDLE: begin
        m0_gnt = pick[0];
        m1_gnt = pick[1];
      end
      OWN0:    m0_gnt = m0_req;
      OWN1:    m1_gnt = m1_req;
      default: ;
    endcase
  end

  // Winner attributes; m0 is the default leg so idle SRAM inputs follow m0
  always_comb begin
    any_gnt  = m0_gnt | m1_gnt;
    win_last = m1_gnt ? m1_last  : m0_last;
    win_wen  = m1_gnt ? m1_wen   : m0_wen;
    win_strb = m1_gnt ? m1_wstrb : m0_wstrb;
    ram_addr = m1_gnt ? m1_addr  : m0_addr;
    ram_din  = m1_gnt ? m1_wdata : m0_wdata;
  end

  // Active-low SRAM strobes; a zero-strobe write still pulses gwen
  always_comb begin
    ram_cen  = ~any_gnt;
    ram_gwen = ~(any_gnt & win_wen);
    ram_wen  = (any_gnt & win_wen) ? ~win_strb : {STRB_W{1'b1}};
  end

  assign m0_rdata = ram_dout;
  assign m1_rdata = ram_dout;

  // Ownership FSM with round-robin pointer, lock watchdog and read-valid flops
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      wd_cnt   <= '0;
      lock_err <= 1'b0;
      m0_rvld  <= 1'b0;
      m1_rvld  <= 1'b0;
    end else begin
      lock_err <= 1'b0;
      m0_rvld  <= m0_gnt & ~m0_wen;
      m1_rvld  <= m1_gnt & ~m1_wen;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (any_gnt) begin
            if (win_last) begin
              // single-beat burst: hand priority to the other side
              rr_ptr <= m0_gnt;
            end else begin
              state <= m1_gnt ? OWN1 : OWN0;
            end
          end
        end
        OWN0: begin
          if (m0_req) begin
            wd_cnt <= '0;
            if (m0_last) begin
              state  <= IDLE;
              rr_ptr <= 1'b1;
            end
          end else if (wd_cnt == WD_LAST) begin
            state    <= IDLE;
            rr_ptr   <= 1'b1;
            lock_err <= 1'b1;
            wd_cnt   <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        OWN1: begin
          if (m1_req) begin
            wd_cnt <= '0;
            if (m1_last) begin
              state  <= IDLE;
              rr_ptr <= 1'b0;
            end
          end else if (wd_cnt == WD_LAST) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            lock_err <= 1'b1;
            wd_cnt   <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          wd_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_port_arb
// Purpose : Scoreboard bench for sram_port_arb: directed scenarios followed by
//           randomized traffic, checked against a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sram_port_arb;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 128;
  localparam int STRB_W  = 16;
  localparam int LOCK_TO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_b;
  logic              m0_req, m0_last, m0_wen, m0_gnt, m0_rvld;
  logic [ADDR_W-1:0] m0_addr;
  logic [STRB_W-1:0] m0_wstrb;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_req, m1_last, m1_wen, m1_gnt, m1_rvld;
  logic [ADDR_W-1:0] m1_addr;
  logic [STRB_W-1:0] m1_wstrb;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic              ram_cen, ram_gwen, lock_err;
  logic [STRB_W-1:0] ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout = '0;

  sram_port_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_TO(LOCK_TO)) dut (
    .clk(clk), .rst_b(rst_b),
    .m0_req(m0_req), .m0_last(m0_last), .m0_addr(m0_addr), .m0_wen(m0_wen),
    .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvld(m0_rvld),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_last(m1_last), .m1_addr(m1_addr), .m1_wen(m1_wen),
    .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvld(m1_rvld),
    .m1_rdata(m1_rdata),
    .ram_cen(ram_cen), .ram_gwen(ram_gwen), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .lock_err(lock_err)
  );

  // Deterministic preload pattern for every row
  function automatic logic [DATA_W-1:0] row_init(input int a);
    logic [31:0] s;
    s = 32'h9E3779B9 * (a + 1);
    return {s, ~s, s ^ 32'h5A5A5A5A, s + 32'd7};
  endfunction

  // Behavioural single-port SRAM macro: active-low strobes, 1-cycle read
  logic [DATA_W-1:0] sram_mem [int];
  always @(posedge clk) begin
    int a;
    logic [DATA_W-1:0] row;
    if (ram_cen === 1'b0) begin
      a   = int'(ram_addr);
      row = sram_mem.exists(a) ? sram_mem[a] : row_init(a);
      if (ram_gwen === 1'b0) begin
        for (int i = 0; i < STRB_W; i++)
          if (!ram_wen[i]) row[i*8 +: 8] = ram_din[i*8 +: 8];
        sram_mem[a] = row;
      end else begin
        ram_dout <= row;
      end
    end
  end

  typedef struct {
    bit                req, last, wen;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } beat_t;

  typedef struct {
    bit                g0, g1, cen, gwen, le;
    logic [STRB_W-1:0] wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } exp_t;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rdq0[$];
  rd_t  rdq1[$];
  int   checks = 0;
  int   errors = 0;
  int   drv_cyc = 0;

  // Reference model state: owner -1 = free, rr = preferred requester
  int   owner = -1;
  int   rr = 0;
  int   idle_cnt = 0;
  bit   le_flag = 1'b0;
  logic [DATA_W-1:0] gold [int];

  function automatic logic [DATA_W-1:0] gold_get(input int a);
    return gold.exists(a) ? gold[a] : row_init(a);
  endfunction

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic beat_t mk(input bit req, input bit last, input bit wen,
                               input logic [ADDR_W-1:0] addr,
                               input logic [STRB_W-1:0] wstrb,
                               input logic [DATA_W-1:0] wdata);
    beat_t b;
    b.req = req; b.last = last; b.wen = wen;
    b.addr = addr; b.wstrb = wstrb; b.wdata = wdata;
    return b;
  endfunction

  function automatic beat_t idle_b();
    return mk(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endfunction

  // Apply one cycle of stimulus and push the model's expected response
  task automatic drive(input beat_t b0, input beat_t b1, input bit rst_in);
    exp_t  e;
    beat_t wb;
    rd_t   r;
    int    win;
    int    a;
    logic [DATA_W-1:0] row;
    @(negedge clk);
    if (!rst_in) begin
      b0.req = 1'b0;
      b1.req = 1'b0;
    end
    rst_b    = rst_in;
    m0_req   = b0.req; m0_last = b0.last; m0_wen = b0.wen;
    m0_addr  = b0.addr; m0_wstrb = b0.wstrb; m0_wdata = b0.wdata;
    m1_req   = b1.req; m1_last = b1.last; m1_wen = b1.wen;
    m1_addr  = b1.addr; m1_wstrb = b1.wstrb; m1_wdata = b1.wdata;
    e.g0 = 0; e.g1 = 0; e.cen = 1; e.gwen = 1; e.le = 0;
    e.wen = '1; e.addr = '0; e.din = '0;
    if (!rst_in) begin
      owner = -1; rr = 0; idle_cnt = 0; le_flag = 0;
      rdq0.delete(); rdq1.delete();
    end else begin
      e.le = le_flag;
      le_flag = 0;
      win = -1;
      if (owner < 0) begin
        if (b0.req && b1.req) win = rr;
        else if (b0.req)      win = 0;
        else if (b1.req)      win = 1;
      end else if ((owner == 0) ? b0.req : b1.req) begin
        win = owner;
      end
      if (win >= 0) begin
        wb     = (win == 1) ? b1 : b0;
        e.g0   = (win == 0);
        e.g1   = (win == 1);
        e.cen  = 0;
        e.addr = wb.addr;
        e.din  = wb.wdata;
        a      = int'(wb.addr);
        if (wb.wen) begin
          e.gwen = 0;
          e.wen  = ~wb.wstrb;
          row = gold_get(a);
          for (int i = 0; i < STRB_W; i++)
            if (wb.wstrb[i]) row[i*8 +: 8] = wb.wdata[i*8 +: 8];
          gold[a] = row;
        end else begin
          r.due  = drv_cyc + 1;
          r.data = gold_get(a);
          if (win == 0) rdq0.push_back(r);
          else          rdq1.push_back(r);
        end
        idle_cnt = 0;
        if (wb.last) begin
          owner = -1;
          rr    = 1 - win;
        end else begin
          owner = win;
        end
      end else if (owner >= 0) begin
        idle_cnt++;
        if (idle_cnt == LOCK_TO) begin
          rr       = 1 - owner;
          owner    = -1;
          idle_cnt = 0;
          le_flag  = 1;
        end
      end
    end
    exp_q.push_back(e);
    drv_cyc++;
  endtask

  // Monitor: pop one expectation per cycle, compare away from the clock edge
  initial begin
    int   mcyc;
    exp_t e;
    rd_t  r;
    bit   ev0, ev1;
    mcyc = 0;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("m0_gnt", DATA_W'(m0_gnt), DATA_W'(e.g0));
        chk("m1_gnt", DATA_W'(m1_gnt), DATA_W'(e.g1));
        chk("ram_cen", DATA_W'(ram_cen), DATA_W'(e.cen));
        chk("lock_err", DATA_W'(lock_err), DATA_W'(e.le));
        if (!e.cen) begin
          chk("ram_gwen", DATA_W'(ram_gwen), DATA_W'(e.gwen));
          chk("ram_wen", DATA_W'(ram_wen), DATA_W'(e.wen));
          chk("ram_addr", DATA_W'(ram_addr), DATA_W'(e.addr));
          chk("ram_din", ram_din, e.din);
        end
        ev0 = (rdq0.size() > 0) && (rdq0[0].due == mcyc);
        ev1 = (rdq1.size() > 0) && (rdq1[0].due == mcyc);
        chk("m0_rvld", DATA_W'(m0_rvld), DATA_W'(ev0));
        chk("m1_rvld", DATA_W'(m1_rvld), DATA_W'(ev1));
        if (ev0) begin
          r = rdq0.pop_front();
          chk("m0_rdata", m0_rdata, r.data);
        end
        if (ev1) begin
          r = rdq1.pop_front();
          chk("m1_rdata", m1_rdata, r.data);
        end
        mcyc++;
      end
    end
  end

  // Hard stop if the run never completes
  initial begin
    #2_000_000;
    $display("FAIL timeout reached before end of stimulus");
    $fatal(1);
  end

  // Stimulus
  initial begin
    int p0, p1;
    beat_t b0, b1;
    rst_b = 1'b0;
    m0_req = 0; m0_last = 0; m0_wen = 0; m0_addr = '0; m0_wstrb = '0; m0_wdata = '0;
    m1_req = 0; m1_last = 0; m1_wen = 0; m1_addr = '0; m1_wstrb = '0; m1_wdata = '0;

    // reset, then a single-beat read of row 0x0010
    repeat (3) drive(idle_b(), idle_b(), 1'b0);
    drive(idle_b(), idle_b(), 1'b1);
    drive(mk(1, 1, 0, 16'h0010, '0, '0), idle_b(), 1'b1);
    drive(idle_b(), idle_b(), 1'b1);

    // both issue single-beat writes: expect strict alternation, no bubble
    for (int i = 0; i < 6; i++)
      drive(mk(1, 1, 1, 16'(i), 16'hFFFF, {4{$urandom}}),
            mk(1, 1, 1, 16'(8 + i), 16'h00FF, {4{$urandom}}), 1'b1);

    // m0 single read moves priority to m1, then m1 4-beat burst vs m0 pressure
    drive(mk(1, 1, 0, 16'h0002, '0, '0), idle_b(), 1'b1);
    for (int i = 0; i < 4; i++)
      drive(mk(1, 1, 0, 16'h0003, '0, '0),
            mk(1, (i == 3), 1, 16'(16'h20 + i), 16'h000F, {4{$urandom}}), 1'b1);
    drive(mk(1, 1, 0, 16'h0020, '0, '0), idle_b(), 1'b1);

    // m0 takes the lock, then stalls while m1 waits: watchdog release
    drive(mk(1, 0, 1, 16'h0005, 16'h0000, {4{$urandom}}), idle_b(), 1'b1);
    for (int i = 0; i < LOCK_TO + 3; i++)
      drive(idle_b(), mk(1, 1, 0, 16'h0021, '0, '0), 1'b1);

    // reset in the middle of an m1 read burst
    drive(idle_b(), mk(1, 0, 0, 16'h0022, '0, '0), 1'b1);
    drive(idle_b(), mk(1, 0, 0, 16'h0023, '0, '0), 1'b1);
    drive(idle_b(), idle_b(), 1'b0);
    drive(idle_b(), idle_b(), 1'b0);
    drive(mk(1, 1, 0, 16'h0001, '0, '0), mk(1, 1, 0, 16'h0002, '0, '0), 1'b1);
    drive(mk(1, 1, 0, 16'h0001, '0, '0), mk(1, 1, 0, 16'h0002, '0, '0), 1'b1);

    // randomized traffic with per-block request densities (0 lets locks stall)
    for (int blk = 0; blk < 30; blk++) begin
      p0 = (blk % 5 == 3) ? 0 : $urandom_range(20, 100);
      p1 = (blk % 7 == 4) ? 0 : $urandom_range(20, 100);
      for (int i = 0; i < 100; i++) begin
        b0 = mk($urandom_range(0, 99) < p0, $urandom_range(0, 99) < 30, $urandom_range(0, 1) == 1,
                16'($urandom_range(0, 7)),
                ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom),
                {$urandom, $urandom, $urandom, $urandom});
        b1 = mk($urandom_range(0, 99) < p1, $urandom_range(0, 99) < 30, $urandom_range(0, 1) == 1,
                16'($urandom_range(0, 7)),
                ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom),
                {$urandom, $urandom, $urandom, $urandom});
        drive(b0, b1, 1'b1);
      end
    end

    repeat (4) drive(idle_b(), idle_b(), 1'b1);
    @(negedge clk);
    #5;
    chk("read_queue_drain", DATA_W'(rdq0.size() + rdq1.size()), '0);
    chk("expect_queue_drain", DATA_W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
